fsk_frame_demod: RTL
====================

// Module: fsk_frame_demod
// PURPOSE
//  Parametrised FSK receive demodulator. Slices sampled carrier, measures zero-crossing intervals, decodes
//  short-pair=1 / long=0 symbols and assembles FRAME_BITS-bit frames into a small FIFO for the host side.
//  Adds hysteresis, rx enable, carrier detect, frame FIFO with valid/ready, interrupt flag/mask.
// PARAMETERS
//  SAMPLE_W     8    width of in_signal (unsigned, midscale-centred)
//  MIDSCALE     128  slicer centre value
//  HYST         0    slicer hysteresis, in LSBs
//  CNT_W        8    interval counter width (saturating)
//  SHORT_THR    24   interval <= SHORT_THR is short, > is long
//  FRAME_BITS   16   bits per frame
//  FIFO_DEPTH   4    frames buffered (power of 2)
//  IDLE_CYCLES  64   edge-free cycles before carrier_det drops
// PORTS
//  G_CLK_RX     in   1                   receive clock; all state on rising edge
//  reset_n      in   1                   asynchronous, active-low reset
//  rx_enable    in   1                   0: discard symbols, clear partial frame
//  in_signal    in   SAMPLE_W            carrier sample, one per clock
//  int_mask     in   1                   1: int_rx may assert
//  int_clr      in   1                   pulse: clears int_flag
//  frame_ready  in   1                   consumer accepts frame_data this cycle
//  frame_data   out  FRAME_BITS          head-of-FIFO frame, first received bit in MSB
//  frame_valid  out  1                   FIFO not empty
//  fifo_level   out  $clog2(FIFO_DEPTH)+1 frames held
//  carrier_det  out  1                   edge seen within last IDLE_CYCLES
//  int_flag     out  1                   sticky: frame pushed since last clear
//  int_rx       out  1                   int_flag & int_mask (registered)
//  overflow     out  1                   sticky: frame dropped on full FIFO; cleared by int_clr
// BEHAVIOUR
//  Reset: every register and output 0; FIFO empty.
//  Slicer (registered): sl<=1 if in_signal>MIDSCALE+HYST; sl<=0 if in_signal<MIDSCALE-HYST; else hold.
//  Edge: two-flop delay of sl, edge pulse registered = d1^d2; crossing at sample n -> edge at n+3.
//  Interval counter: cleared on edge cycle, else +1, saturates at 2**CNT_W-1 (saturated = long).
//   Value sampled on edge = cycles since previous edge - 1. Equal to SHORT_THR counts as short.
//  Symbol FSM states IDLE, HALF: IDLE+short->HALF; HALF+short->IDLE, emit bit 1;
//   any long->IDLE, emit bit 0 (a pending HALF is dropped). Emit = 1-cycle bit_valid next cycle.
//  First edge after reset/carrier acquisition only starts the interval; no symbol.
//  Assembler: shift left, new bit into LSB, bit counter 0..FRAME_BITS-1; on FRAME_BITS-th bit,
//   frame pushed to FIFO next cycle, counter wraps to 0; frame_valid visible cycle after push.
//  rx_enable=0 or carrier_det falling: FSM->IDLE, shift reg and bit counter cleared same cycle.
//  carrier_det: 1 on any edge; 0 after IDLE_CYCLES consecutive edge-free cycles.
//  FIFO: pop when frame_valid&frame_ready. Push on full without pop: frame dropped, overflow<=1.
//   Push+pop same cycle when full: both accepted, level unchanged. Order strictly FIFO.
//  int_flag set on each accepted push; int_clr clears int_flag, overflow; set wins over clear.
//  int_rx = registered int_flag&int_mask, one cycle after int_flag.
//  Async reset mid-frame: everything 0 immediately, FIFO contents lost.
// STRUCTURE
//  Package fsk_demod_pkg: symbol enum (SYM_IDLE, SYM_HALF), default parameter localparams,
//   frame_t typedef logic [FRAME_BITS-1:0].
//  Sub-module frame_fifo: synchronous FIFO (depth, width params, level, full/empty, push/pop).
//  Top holds slicer, edge detect, interval counter, symbol FSM, assembler, carrier/interrupt logic.
// TESTING
//  1 reset_n=0 mid-stream -> all outputs 0 within same cycle; after release, no frame until 16 new bits.
//  2 sinewave, 32-sample period (half-period 16, short), rx_enable=1, ready=1 -> frame 16'hFFFF, int_flag=1.
//  3 half-periods long(32)x16 -> 16'h0000; mixed pattern encoding 16'hA5C3 -> frame_data=16'hA5C3.
//  4 frame_ready=0, send 5 frames -> fifo_level=4, overflow=1; then ready=1 pops frames 1..4 in order.
//  5 rx_enable low after 7 bits, then high, send 16'h1234 -> exactly one frame 16'h1234.
//  6 hold in_signal=128 IDLE_CYCLES after 5 bits -> carrier_det 0, partial cleared; int_clr with push -> flag stays 1.

Source files
------------

// File: rtl/fsk_frame_demod_pkg.sv
// Shared types and default parameter values for the FSK frame demodulator.
package fsk_demod_pkg;

    localparam int unsigned DEF_SAMPLE_W    = 8;
    localparam int unsigned DEF_MIDSCALE    = 128;
    localparam int unsigned DEF_HYST        = 0;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_SHORT_THR   = 24;
    localparam int unsigned DEF_FRAME_BITS  = 16;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_IDLE_CYCLES = 64;

    typedef enum logic {
        SYM_IDLE = 1'b0,
        SYM_HALF = 1'b1
    } sym_state_e;

    typedef logic [DEF_FRAME_BITS-1:0] frame_t;

endpackage

// File: rtl/fsk_frame_demod_if.sv
// Host-side frame/interrupt bus of the FSK frame demodulator.
interface fsk_frame_demod_if
    import fsk_demod_pkg::*;
#(
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

    logic [FRAME_BITS-1:0]         frame_data;
    logic                          frame_valid;
    logic                          frame_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          int_mask;
    logic                          int_clr;
    logic                          int_flag;
    logic                          int_rx;
    logic                          overflow;

    modport master (
        output frame_data, frame_valid, fifo_level, int_flag, int_rx, overflow,
        input  frame_ready, int_mask, int_clr
    );

    modport slave (
        input  frame_data, frame_valid, fifo_level, int_flag, int_rx, overflow,
        output frame_ready, int_mask, int_clr
    );

endinterface

// File: rtl/fsk_frame_demod_frame_fifo.sv
// Synchronous frame FIFO; DEPTH must be a power of two >= 2.
module frame_fifo
    import fsk_demod_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEF_FRAME_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // Pointer/level bookkeeping; a push on full is accepted only alongside a pop.
    always_comb begin
        do_pop   = pop & (level_q != '0);
        do_push  = push & ((level_q != LVL_FULL) | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);

endmodule

// File: rtl/fsk_frame_demod.sv
// FSK receive demodulator: slicer, zero-crossing interval decode, frame assembly and host FIFO.
module fsk_frame_demod
    import fsk_demod_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned MIDSCALE    = DEF_MIDSCALE,
    parameter int unsigned HYST        = DEF_HYST,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SHORT_THR   = DEF_SHORT_THR,
    parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic                G_CLK_RX,
    input  logic                reset_n,
    input  logic                rx_enable,
    input  logic [SAMPLE_W-1:0] in_signal,
    output logic                carrier_det,
    fsk_frame_demod_if.master   host
);

    localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [SAMPLE_W:0]   HI_THR    = (SAMPLE_W+1)'(MIDSCALE + HYST);
    localparam logic [SAMPLE_W:0]   LO_THR    = (SAMPLE_W+1)'(MIDSCALE - HYST);
    localparam logic [CNT_W-1:0]    SHORT_MAX = CNT_W'(SHORT_THR);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    logic                  sl_q, sl_d;
    logic                  d1_q, d1_d;
    logic                  d2_q, d2_d;
    logic                  edge_q, edge_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  carrier_q, carrier_d;
    sym_state_e            state_q, state_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
    logic                  push_q, push_d;
    logic [FRAME_BITS-1:0] push_data_q, push_data_d;
    logic                  int_flag_q, int_flag_d;
    logic                  int_rx_q, int_rx_d;
    logic                  overflow_q, overflow_d;

    logic [SAMPLE_W:0]     samp;
    logic                  flush;
    logic                  short_sym;
    logic                  fifo_full, fifo_empty;
    logic                  pop, push_accept, push_drop;

    // Slicer with hysteresis, edge pipeline, interval and carrier-idle counters.
    always_comb begin
        samp = {1'b0, in_signal};
        sl_d = sl_q;
        if (samp > HI_THR) begin
            sl_d = 1'b1;
        end else if (samp < LO_THR) begin
            sl_d = 1'b0;
        end
        d1_d   = sl_q;
        d2_d   = d1_q;
        edge_d = d1_q ^ d2_q;
        cnt_d  = edge_q ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
        if (edge_q) begin
            idle_d    = '0;
            carrier_d = 1'b1;
        end else begin
            idle_d    = (idle_q >= IDLE_LAST) ? idle_q : idle_q + 1'b1;
            carrier_d = (idle_q >= IDLE_LAST) ? 1'b0 : carrier_q;
        end
        flush = ~rx_enable | (carrier_q & ~carrier_d);
    end

    // Symbol FSM: two shorts make a 1, any long makes a 0; the acquisition edge only starts timing.
    always_comb begin
        short_sym   = (cnt_q <= SHORT_MAX);
        state_d     = state_q;
        bit_valid_d = 1'b0;
        bit_d       = 1'b0;
        if (flush) begin
            state_d = SYM_IDLE;
        end else if (edge_q && carrier_q) begin
            if (!short_sym) begin
                state_d     = SYM_IDLE;
                bit_valid_d = 1'b1;
            end else begin
                case (state_q)
                    SYM_IDLE: state_d = SYM_HALF;
                    SYM_HALF: begin
                        state_d     = SYM_IDLE;
                        bit_valid_d = 1'b1;
                        bit_d       = 1'b1;
                    end
                    default:  state_d = SYM_IDLE;
                endcase
            end
        end
    end

    // Frame assembler: MSB-first shift, frame handed to the FIFO the cycle after its last bit.
    always_comb begin
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (flush) begin
            shift_d  = '0;
            bitcnt_d = '0;
        end else if (bit_valid_q) begin
            shift_d = {shift_q[FRAME_BITS-2:0], bit_q};
            if (bitcnt_q == BIT_LAST) begin
                bitcnt_d    = '0;
                push_d      = 1'b1;
                push_data_d = shift_d;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    // Interrupt flag and overflow are sticky; a same-cycle set beats int_clr.
    always_comb begin
        pop         = ~fifo_empty & host.frame_ready;
        push_drop   = push_q & fifo_full & ~pop;
        push_accept = push_q & ~push_drop;
        int_flag_d  = int_flag_q;
        overflow_d  = overflow_q;
        if (host.int_clr) begin
            int_flag_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (push_accept) begin
            int_flag_d = 1'b1;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end
        int_rx_d = int_flag_q & host.int_mask;
    end

    // Symbol FSM state register.
    always_ff @(posedge G_CLK_RX or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SYM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge G_CLK_RX or negedge reset_n) begin
        if (!reset_n) begin
            sl_q        <= 1'b0;
            d1_q        <= 1'b0;
            d2_q        <= 1'b0;
            edge_q      <= 1'b0;
            cnt_q       <= '0;
            idle_q      <= '0;
            carrier_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_q       <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            int_flag_q  <= 1'b0;
            int_rx_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sl_q        <= sl_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            carrier_q   <= carrier_d;
            bit_valid_q <= bit_valid_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            int_flag_q  <= int_flag_d;
            int_rx_q    <= int_rx_d;
            overflow_q  <= overflow_d;
        end
    end

    frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk       (G_CLK_RX),
        .rst_n     (reset_n),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .pop_data  (host.frame_data),
        .level     (host.fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign host.frame_valid = ~fifo_empty;
    assign host.int_flag    = int_flag_q;
    assign host.int_rx      = int_rx_q;
    assign host.overflow    = overflow_q;
    assign carrier_det      = carrier_q;

endmodule
